seg14_scroll_mux: RTL and testbench
===================================

// Module: seg14_scroll_mux
// PURPOSE
//  Parametrised multiplexed 14-segment display driver with character font and scrolling.
//  - Holds a writable message of 6-bit character codes.
//  - Scans N_DIGITS one-hot digit selects, each for REFRESH_DIV clocks.
//  - In scroll mode the message window advances one character every SCROLL_FRAMES frames.
//  - Sits between the user-project register interface and the display pads; replaces fixed-text drivers.
// PARAMETERS
//  N_DIGITS       12    number of digits; width of sel
//  MSG_DEPTH      32    message buffer entries; power of two
//  REFRESH_DIV    1024  clocks per digit slot; must be >= 2
//  SCROLL_FRAMES  64    full scan frames per scroll step; must be >= 1
//  SEL_ACT_LOW    0     1: sel is driven active-low (one-cold)
// PORTS
//  clk         in   1                   single system clock; all logic is on its rising edge
//  rst         in   1                   synchronous, active-high reset
//  wr_en       in   1                   write one message character
//  wr_addr     in   $clog2(MSG_DEPTH)   message index
//  wr_data     in   6                   character code
//  msg_len     in   $clog2(MSG_DEPTH)+1 valid characters; values > MSG_DEPTH are clamped to MSG_DEPTH
//  scroll_en   in   1                   1: scroll mode; 0: static mode, window fixed at index 0
//  sel         out  N_DIGITS            digit select, one-hot (one-cold if SEL_ACT_LOW)
//  segm        out  14                  segment pattern; bit13 = segment a ... bit0
//  frame_tick  out  1                   1-clk pulse when the last digit slot ends
// BEHAVIOUR
//  - Reset values:
//    - sel = all inactive; segm = 0; frame_tick = 0.
//    - presc = 0, digit = 0, frames = 0, offset = 0.
//    - All message entries = 0 (space).
//  - Prescaler: presc counts 0..REFRESH_DIV-1 and wraps. On the wrap, digit advances.
//    - digit wraps from N_DIGITS-1 to 0; that wrap is the end of a frame.
//  - Character selection: idx = offset + digit, taken modulo the effective length L.
//    - Static mode: a digit whose position is >= L shows blank.
//    - Scroll mode: idx always wraps modulo L.
//    - L = 0: every digit shows blank; sel keeps scanning.
//  - Outputs are registered. sel and segm reflect the new digit 1 clk after digit changes.
//    - They are held constant for the whole digit slot.
//  - frame_tick is high for exactly 1 clk, coincident with the digit wrap N_DIGITS-1 -> 0.
//  - Scroll stepping:
//    - At each frame end with scroll_en=1, frames increments.
//    - When frames = SCROLL_FRAMES-1: frames returns to 0 and offset = (offset+1) mod L.
//    - scroll_en=0 forces offset and frames to 0 at the next clk.
//  - msg_len change: if offset >= new L, offset is forced to 0 at the next frame end.
//    - Until then, idx still wraps modulo the new L.
//  - Writes take effect on the next clk edge.
//    - A write to the character being displayed appears at the next slot of that digit.
//    - The current slot is not glitched.
//  - Font lookup for undefined character codes (38..63) returns blank (14'b0).
//  - rst asserted mid-scan returns every counter to its reset value on that clk.
//    - The message buffer is cleared as well.
// STRUCTURE
//  - Package seg14_pkg contains:
//    - The char-code constants: 0 = space, 1..26 = A..Z, 27 = N-tilde, 28..37 = digits 0..9.
//    - The 14-bit font localparams.
//    - The function clog2 helpers.
//  - One sub-module, seg14_font: purely combinational code -> pattern ROM, using the package constants.
//  - The top level holds the prescaler, digit/frame/offset counters, message register file and output registers.
// TESTING
//  1. Reset: assert rst for 3 clks -> sel=0, segm=0, frame_tick=0; after release, first sel=12'h001 and segm=0.
//  2. Static text: REFRESH_DIV=4, load "TEC" (20,5,3), msg_len=3, scroll_en=0.
//     - Digit0 shows 14'b10000000010010.
//     - Digit1 shows 14'b10011110000000.
//     - Digit2 shows 14'b10011100000000.
//     - Digits 3..11 show 0.
//     - Each digit is held for 4 clks.
//  3. Scroll: msg_len=3, SCROLL_FRAMES=1, scroll_en=1.
//     - After one frame_tick, digit0 shows 'E'.
//     - After the third frame_tick, digit0 shows 'T' (wrap).
//     - Digit3 shows 'T' while offset = 0.
//  4. Boundaries:
//     - msg_len=0 -> all segm=0 while sel scans.
//     - msg_len=40 is clamped to 32.
//     - Code 50 -> blank.
//     - Shrinking msg_len below offset resets offset to 0 at the next frame end.
//  5. Write during display: write 'A' into the index currently shown.
//     - segm is unchanged for the rest of the slot.
//     - The next visit of that digit shows 14'b11101111000000.
//  6. Mid-operation reset: rst pulses while digit=7 and offset=2 -> next clk all counters are 0 and the message is cleared.

Source files
------------

// File: rtl/seg14_pkg.sv
// Shared character codes, 14-segment font table and width helpers for the
// multiplexed 14-segment display driver.
package seg14_pkg;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Register width able to hold 0..value-1, never narrower than one bit.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  localparam int CODE_W = 6;
  localparam int SEG_W  = 14;

  // Character codes.
  localparam logic [CODE_W-1:0] CH_SPACE  = 6'd0;
  localparam logic [CODE_W-1:0] CH_A      = 6'd1;
  localparam logic [CODE_W-1:0] CH_Z      = 6'd26;
  localparam logic [CODE_W-1:0] CH_NTILDE = 6'd27;
  localparam logic [CODE_W-1:0] CH_DIG0   = 6'd28;
  localparam logic [CODE_W-1:0] CH_DIG9   = 6'd37;

  localparam int FONT_ENTRIES = 38;

  // Segment order, bit13..bit0: a b c d e f g1 g2 h i j k l m
  // (h/j upper diagonals, i upper centre bar, k/m lower diagonals, l lower centre bar).
  localparam logic [SEG_W-1:0] FONT_ROM [FONT_ENTRIES] = '{
    14'b00000000000000,  // space
    14'b11101111000000,  // A
    14'b11110001010010,  // B
    14'b10011100000000,  // C
    14'b11110000010010,  // D
    14'b10011110000000,  // E
    14'b10001110000000,  // F
    14'b10111101000000,  // G
    14'b01101111000000,  // H
    14'b10010000010010,  // I
    14'b01111000000000,  // J
    14'b00001110001001,  // K
    14'b00011100000000,  // L
    14'b01101100101000,  // M
    14'b01101100100001,  // N
    14'b11111100000000,  // O
    14'b11001111000000,  // P
    14'b11111100000001,  // Q
    14'b11001111000001,  // R
    14'b10110111000000,  // S
    14'b10000000010010,  // T
    14'b01111100000000,  // U
    14'b00001100001100,  // V
    14'b01101100000101,  // W
    14'b00000000101101,  // X
    14'b00000000101010,  // Y
    14'b10010000001100,  // Z
    14'b11101100100001,  // N-tilde
    14'b11111100001100,  // 0
    14'b01100000001000,  // 1
    14'b11011011000000,  // 2
    14'b11110001000000,  // 3
    14'b01100111000000,  // 4
    14'b10110111000000,  // 5
    14'b10111111000000,  // 6
    14'b11100000000000,  // 7
    14'b11111111000000,  // 8
    14'b11110111000000   // 9
  };

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to 14-segment pattern ROM.
module seg14_font
  import seg14_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  pattern
);

  // Table lookup; codes past the last defined glyph render blank.
  always_comb begin
    pattern = 14'b0;
    if (code <= CH_DIG9) begin
      pattern = FONT_ROM[code];
    end else begin
      pattern = 14'b0;
    end
  end

endmodule

// File: rtl/seg14_scroll_mux.sv
// Multiplexed 14-segment display driver: message buffer, digit scan,
// optional scrolling window and registered pad outputs.
module seg14_scroll_mux
  import seg14_pkg::*;
#(
  parameter int N_DIGITS      = 12,
  parameter int MSG_DEPTH     = 32,
  parameter int REFRESH_DIV   = 1024,
  parameter int SCROLL_FRAMES = 64,
  parameter bit SEL_ACT_LOW   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [5:0]                   wr_data,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         scroll_en,
  output logic [N_DIGITS-1:0]          sel,
  output logic [13:0]                  segm,
  output logic                         frame_tick
);

  localparam int AW = clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = width_of(N_DIGITS);
  localparam int PW = width_of(REFRESH_DIV);
  localparam int FW = width_of(SCROLL_FRAMES);
  // Wide enough for offset + digit without overflow.
  localparam int CW = ((AW > DW) ? AW : DW) + 2;

  localparam logic [PW-1:0]       PRESC_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]       DIGIT_LAST  = DW'(N_DIGITS - 1);
  localparam logic [FW-1:0]       FRAMES_LAST = FW'(SCROLL_FRAMES - 1);
  localparam logic [LW-1:0]       LEN_MAX     = LW'(MSG_DEPTH);
  localparam logic [N_DIGITS-1:0] SEL_IDLE    = {N_DIGITS{SEL_ACT_LOW}};

  logic [PW-1:0]     presc_r;
  logic [DW-1:0]     digit_r;
  logic [FW-1:0]     frames_r, frames_n_s;
  logic [AW-1:0]     offset_r, offset_n_s;
  logic              load_r;
  logic [CODE_W-1:0] msg_r [MSG_DEPTH];

  logic              presc_wrap_s, frame_end_s, blank_s;
  logic [LW-1:0]     len_s;
  logic [CW-1:0]     pos_s, len_c_s, div_s;
  logic [AW-1:0]     idx_s;
  logic [CODE_W-1:0] code_s;
  logic [SEG_W-1:0]  pattern_s;
  logic [N_DIGITS-1:0] onehot_s;

  // Scan timing strobes and the clamped effective message length.
  always_comb begin
    presc_wrap_s = (presc_r == PRESC_LAST);
    frame_end_s  = presc_wrap_s && (digit_r == DIGIT_LAST);
    if (msg_len > LEN_MAX) begin
      len_s = LEN_MAX;
    end else begin
      len_s = msg_len;
    end
  end

  // Pick the character for the current digit; divisor forced to 1 when the message is empty.
  always_comb begin
    pos_s   = CW'(offset_r) + CW'(digit_r);
    len_c_s = CW'(len_s);
    div_s   = (len_s == LW'(0)) ? CW'(1) : len_c_s;
    blank_s = (len_s == LW'(0)) || (!scroll_en && (pos_s >= len_c_s));
    idx_s   = AW'(pos_s % div_s);
    code_s  = blank_s ? CH_SPACE : msg_r[idx_s];
    onehot_s = N_DIGITS'(1) << digit_r;
  end

  seg14_font u_font (
    .code    (code_s),
    .pattern (pattern_s)
  );

  // Scroll window: cleared in static mode; a stale offset past the length snaps to 0 at frame end.
  always_comb begin
    offset_n_s = offset_r;
    frames_n_s = frames_r;
    if (!scroll_en) begin
      offset_n_s = {AW{1'b0}};
      frames_n_s = {FW{1'b0}};
    end else if (frame_end_s) begin
      if (frames_r == FRAMES_LAST) begin
        frames_n_s = {FW{1'b0}};
      end else begin
        frames_n_s = frames_r + FW'(1);
      end
      if (LW'(offset_r) >= len_s) begin
        offset_n_s = {AW{1'b0}};
      end else if (frames_r == FRAMES_LAST) begin
        offset_n_s = ((LW'(offset_r) + LW'(1)) >= len_s) ? {AW{1'b0}} : (offset_r + AW'(1));
      end else begin
        offset_n_s = offset_r;
      end
    end else begin
      offset_n_s = offset_r;
      frames_n_s = frames_r;
    end
  end

  // Prescaler, digit scan and scroll counters; load_r marks the first clock of a digit slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r  <= {PW{1'b0}};
      digit_r  <= {DW{1'b0}};
      frames_r <= {FW{1'b0}};
      offset_r <= {AW{1'b0}};
      load_r   <= 1'b1;
    end else begin
      presc_r  <= presc_wrap_s ? {PW{1'b0}} : (presc_r + PW'(1));
      if (presc_wrap_s) begin
        digit_r <= (digit_r == DIGIT_LAST) ? {DW{1'b0}} : (digit_r + DW'(1));
      end
      frames_r <= frames_n_s;
      offset_r <= offset_n_s;
      load_r   <= presc_wrap_s;
    end
  end

  // Message register file; cleared to spaces on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_r[i] <= CH_SPACE;
      end
    end else if (wr_en) begin
      msg_r[wr_addr] <= wr_data;
    end
  end

  // Pad registers: sel/segm sampled once per slot so writes never glitch a lit digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= SEL_IDLE;
      segm       <= 14'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end_s;
      if (load_r) begin
        sel  <= onehot_s ^ SEL_IDLE;
        segm <= pattern_s;
      end
    end
  end

endmodule

// File: tb/tb_seg14_scroll_mux.sv
// Directed bench for seg14_scroll_mux: static text table, scrolling,
// length boundaries, write-while-lit and mid-scan reset.
module tb_seg14_scroll_mux;

  localparam logic [13:0] P_T = 14'b10000000010010;
  localparam logic [13:0] P_E = 14'b10011110000000;
  localparam logic [13:0] P_C = 14'b10011100000000;
  localparam logic [13:0] P_A = 14'b11101111000000;
  localparam logic [13:0] P_0 = 14'b00000000000000;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [5:0]  wr_data;
  logic [5:0]  msg_len;
  logic        scroll_en;
  logic [11:0] sel;
  logic [13:0] segm;
  logic        frame_tick;

  int total;
  int bad;
  int cnt;

  typedef struct {
    logic [5:0]  len;
    logic [11:0] sel_exp;
    logic [13:0] seg_exp;
  } vec_t;

  vec_t vecs [13];

  seg14_scroll_mux #(
    .N_DIGITS      (12),
    .MSG_DEPTH     (32),
    .REFRESH_DIV   (4),
    .SCROLL_FRAMES (1),
    .SEL_ACT_LOW   (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .msg_len    (msg_len),
    .scroll_en  (scroll_en),
    .sel        (sel),
    .segm       (segm),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for a freshly loaded slot showing the given select.
  task automatic wait_sel(input logic [11:0] target);
    int n;
    n = 0;
    while (sel == target && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (sel != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL wait_sel: sel=%h never reached %h", sel, target);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL wait_tick: frame_tick=%b after %0d clks, want 1", frame_tick, n);
    end
  endtask

  task automatic write_char(input logic [4:0] addr, input logic [5:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = 5'd0;
    wr_data = 6'd0;
    msg_len = 6'd0;
    scroll_en = 1'b0;

    vecs[0]  = '{6'd3,  12'h001, P_T};
    vecs[1]  = '{6'd3,  12'h002, P_E};
    vecs[2]  = '{6'd3,  12'h004, P_C};
    vecs[3]  = '{6'd3,  12'h008, P_0};
    vecs[4]  = '{6'd3,  12'h080, P_0};
    vecs[5]  = '{6'd3,  12'h800, P_0};
    vecs[6]  = '{6'd0,  12'h001, P_0};
    vecs[7]  = '{6'd0,  12'h004, P_0};
    vecs[8]  = '{6'd40, 12'h001, P_T};
    vecs[9]  = '{6'd40, 12'h004, P_C};
    vecs[10] = '{6'd40, 12'h010, P_0};
    vecs[11] = '{6'd40, 12'h200, P_A};
    vecs[12] = '{6'd40, 12'h800, P_0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'(sel), 32'h000);
    check("rst_segm", 32'(segm), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("first_sel", 32'(sel), 32'h001);
    check("first_segm", 32'(segm), 32'h0);

    // Message: T E C, code 50 at 4, A at 9
    write_char(5'd0, 6'd20);
    write_char(5'd1, 6'd5);
    write_char(5'd2, 6'd3);
    write_char(5'd4, 6'd50);
    write_char(5'd9, 6'd1);
    msg_len = 6'd3;

    // Slot length
    wait_sel(12'h002);
    cnt = 0;
    while (sel == 12'h002 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("slot_len", 32'(cnt), 32'd4);

    // Static table
    for (int i = 0; i < 13; i++) begin
      msg_len = vecs[i].len;
      scroll_en = 1'b0;
      wait_sel(vecs[i].sel_exp);
      check($sformatf("vec%0d_segm", i), 32'(segm), 32'(vecs[i].seg_exp));
    end

    // Scrolling over "TEC"
    msg_len = 6'd3;
    wait_tick();
    check("tick_sel_last", 32'(sel), 32'h800);
    scroll_en = 1'b1;
    @(negedge clk);
    check("tick_width", 32'(frame_tick), 32'h0);
    check("scr0_d0", 32'(segm), 32'(P_T));
    wait_sel(12'h008);
    check("scr0_d3", 32'(segm), 32'(P_T));
    wait_sel(12'h010);
    check("scr0_d4", 32'(segm), 32'(P_E));
    wait_tick(); @(negedge clk);
    check("scr1_sel", 32'(sel), 32'h001);
    check("scr1_d0", 32'(segm), 32'(P_E));
    wait_tick(); @(negedge clk);
    check("scr2_d0", 32'(segm), 32'(P_C));
    wait_tick(); @(negedge clk);
    check("scr3_d0_wrap", 32'(segm), 32'(P_T));
    wait_tick(); @(negedge clk);
    check("scr4_d0", 32'(segm), 32'(P_E));
    wait_tick(); @(negedge clk);
    check("scr5_d0", 32'(segm), 32'(P_C));

    // Shrink length below offset 2
    msg_len = 6'd2;
    wait_sel(12'h002);
    check("shrink_d1", 32'(segm), 32'(P_E));
    wait_sel(12'h004);
    check("shrink_d2", 32'(segm), 32'(P_T));
    wait_tick(); @(negedge clk);
    check("shrink_reset_d0", 32'(segm), 32'(P_T));
    wait_tick(); @(negedge clk);
    check("shrink_next_d0", 32'(segm), 32'(P_E));

    // Back to static
    scroll_en = 1'b0;
    msg_len = 6'd3;
    wait_sel(12'h001);
    check("static_again_d0", 32'(segm), 32'(P_T));

    // Write into the digit being shown
    wait_sel(12'h001);
    write_char(5'd0, 6'd1);
    check("wr_hold_sel", 32'(sel), 32'h001);
    check("wr_hold_segm", 32'(segm), 32'(P_T));
    wait_sel(12'h001);
    check("wr_next_visit", 32'(segm), 32'(P_A));
    write_char(5'd0, 6'd20);

    // Mid-scan reset at digit 7, offset 2
    scroll_en = 1'b1;
    wait_tick();
    wait_tick();
    wait_sel(12'h080);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_sel", 32'(sel), 32'h000);
    check("mrst_segm", 32'(segm), 32'h0);
    check("mrst_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_first_sel", 32'(sel), 32'h001);
    check("mrst_msg_cleared", 32'(segm), 32'h0);
    cnt = 0;
    while (sel == 12'h001 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("mrst_slot_len", 32'(cnt), 32'd4);
    write_char(5'd0, 6'd20);
    wait_sel(12'h008);
    check("mrst_offset0_d3", 32'(segm), 32'(P_T));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
